projectile_pool: RTL and testbench

Parametrised per-player projectile manager that replaces the fixed three-bullet generate loop and ad-hoc shoot/allocation logic in the game top level. It owns N_SLOTS bullet slots and performs fire-edge detection, cooldown, slot allocation, motion, lifetime expiry, screen-edge retirement, wall retirement (optionally wall bounce) and hit detection against one opponent. Everything advances once per `frame_tick` strobe in the `clk` domain. One instance is used per player.

---
 rtl/projectile_pool.sv | 259 +++++++++++++++++++++++++
 tb/tb_projectile_pool.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/projectile_pool.sv
// projectile_pool: per-player bullet slots with fire-edge detection, cooldown, allocation,
// motion, lifetime/edge/wall retirement and target hit detection. Define PROJ_BOUNCE_EN for wall bounce.
module projectile_pool #(
   parameter int N_SLOTS  = 3,
   parameter int COORD_W  = 10,
   parameter int SPEED    = 4,
   parameter int BULLET_S = 4,
   parameter int LIFETIME = 120,
   parameter int COOLDOWN = 8,
   parameter int X_MAX    = 639,
   parameter int Y_MAX    = 479
) (
   input  logic                         clk,
   input  logic                         reset_ah,
   input  logic                         frame_tick,
   input  logic                         fire,
   input  logic [1:0]                   fire_dir,
   input  logic                         multi_en,
   input  logic                         block_fire,
   input  logic [COORD_W-1:0]           player_x,
   input  logic [COORD_W-1:0]           player_y,
   input  logic [N_SLOTS-1:0]           wall_hit,
   input  logic [COORD_W-1:0]           target_x,
   input  logic [COORD_W-1:0]           target_y,
   input  logic [COORD_W-1:0]           target_s,
   output logic [N_SLOTS*COORD_W-1:0]   bullet_x,
   output logic [N_SLOTS*COORD_W-1:0]   bullet_y,
   output logic [N_SLOTS-1:0]           active,
   output logic                         hit_pulse,
   output logic [7:0]                   shots
);

   localparam int EW = COORD_W + 2;
   localparam logic [EW-1:0]      SPEED_W   = EW'(SPEED);
   localparam logic [EW-1:0]      BS_W      = EW'(BULLET_S);
   localparam logic [EW-1:0]      X_LIM     = EW'(X_MAX - BULLET_S + 1);
   localparam logic [EW-1:0]      Y_LIM     = EW'(Y_MAX - BULLET_S + 1);
   localparam logic [COORD_W-1:0] STEP      = COORD_W'(SPEED);
   localparam logic [7:0]         AGE_LAST  = 8'(LIFETIME - 1);
   localparam logic [7:0]         COOL_LOAD = 8'(COOLDOWN);
   localparam logic [1:0]         DIR_UP    = 2'b00;
   localparam logic [1:0]         DIR_DOWN  = 2'b01;
   localparam logic [1:0]         DIR_LEFT  = 2'b10;
   localparam logic [1:0]         DIR_RIGHT = 2'b11;

   logic [1:0]          rst_sync_r;
   logic                rst_s;

   logic [COORD_W-1:0]  x_r   [N_SLOTS];
   logic [COORD_W-1:0]  y_r   [N_SLOTS];
   logic [1:0]          dir_r [N_SLOTS];
   logic [7:0]          age_r [N_SLOTS];
   logic [COORD_W-1:0]  x_n   [N_SLOTS];
   logic [COORD_W-1:0]  y_n   [N_SLOTS];
   logic [1:0]          dir_n [N_SLOTS];
   logic [7:0]          age_n [N_SLOTS];
   logic [N_SLOTS-1:0]  act_r;
   logic [N_SLOTS-1:0]  act_n;
`ifdef PROJ_BOUNCE_EN
   logic [N_SLOTS-1:0]  bnc_r;
   logic [N_SLOTS-1:0]  bnc_n;
`endif

   logic [7:0]          cool_r;
   logic [7:0]          cool_n;
   logic [7:0]          shots_r;
   logic [7:0]          shots_n;
   logic                fire_prev_r;
   logic                hit_r;

   logic                accept_s;
   logic                found_s;
   logic                any_hit_s;
   int                  free_idx_s;
   int                  act_cnt_s;
   int                  limit_s;

   // Half-open interval overlap of a bullet span against a target span on one axis.
   function automatic logic overlap(input logic [COORD_W-1:0] p,
                                    input logic [COORD_W-1:0] t,
                                    input logic [COORD_W-1:0] s);
      logic [EW-1:0] pe;
      logic [EW-1:0] te;
      logic [EW-1:0] se;
      pe = EW'(p);
      te = EW'(t);
      se = EW'(s);
      return (pe < te + se) && (te < pe + BS_W);
   endfunction

   function automatic logic leaves_field(input logic [1:0]         d,
                                         input logic [COORD_W-1:0] x,
                                         input logic [COORD_W-1:0] y);
      logic r;
      case (d)
         DIR_UP:    r = EW'(y) < SPEED_W;
         DIR_DOWN:  r = (EW'(y) + SPEED_W) > Y_LIM;
         DIR_LEFT:  r = EW'(x) < SPEED_W;
         DIR_RIGHT: r = (EW'(x) + SPEED_W) > X_LIM;
         default:   r = 1'b1;
      endcase
      return r;
   endfunction

   // Reset asserts asynchronously and releases on the clock.
   always_ff @(posedge clk or posedge reset_ah) begin
      if (reset_ah) begin
         rst_sync_r <= 2'b11;
      end else begin
         rst_sync_r <= {rst_sync_r[0], 1'b0};
      end
   end

   assign rst_s = rst_sync_r[1];

   // Occupancy count, free-slot search and shot acceptance on pre-tick state.
   always_comb begin
      act_cnt_s  = 0;
      free_idx_s = 0;
      found_s    = 1'b0;
      for (int i = 0; i < N_SLOTS; i++) begin
         if (act_r[i]) begin
            act_cnt_s = act_cnt_s + 1;
         end else if (!found_s) begin
            found_s    = 1'b1;
            free_idx_s = i;
         end else begin
            found_s = found_s;
         end
      end
      limit_s  = multi_en ? N_SLOTS : 1;
      accept_s = fire && !fire_prev_r && !block_fire && (cool_r == 8'd0)
                 && (act_cnt_s < limit_s) && found_s;
      if (accept_s) begin
         cool_n = COOL_LOAD;
      end else if (cool_r != 8'd0) begin
         cool_n = cool_r - 8'd1;
      end else begin
         cool_n = cool_r;
      end
      if (accept_s && (shots_r != 8'hFF)) begin
         shots_n = shots_r + 8'd1;
      end else begin
         shots_n = shots_r;
      end
   end

   // Per-slot next state: hit, wall, expiry, edge, then motion; idle slot may take a spawn.
   always_comb begin
      any_hit_s = 1'b0;
      for (int i = 0; i < N_SLOTS; i++) begin
         act_n[i] = act_r[i];
         x_n[i]   = x_r[i];
         y_n[i]   = y_r[i];
         dir_n[i] = dir_r[i];
         age_n[i] = age_r[i];
`ifdef PROJ_BOUNCE_EN
         bnc_n[i] = bnc_r[i];
`endif
         if (act_r[i]) begin
            if (overlap(x_r[i], target_x, target_s) && overlap(y_r[i], target_y, target_s)) begin
               act_n[i]  = 1'b0;
               any_hit_s = 1'b1;
            end else if (wall_hit[i]) begin
`ifdef PROJ_BOUNCE_EN
               if (!bnc_r[i]) begin
                  // Flipping bit 0 swaps up/down and left/right.
                  dir_n[i] = dir_r[i] ^ 2'b01;
                  bnc_n[i] = 1'b1;
                  age_n[i] = age_r[i] + 8'd1;
               end else begin
                  act_n[i] = 1'b0;
               end
`else
               act_n[i] = 1'b0;
`endif
            end else if (age_r[i] == AGE_LAST) begin
               act_n[i] = 1'b0;
            end else if (leaves_field(dir_r[i], x_r[i], y_r[i])) begin
               act_n[i] = 1'b0;
            end else begin
               age_n[i] = age_r[i] + 8'd1;
               case (dir_r[i])
                  DIR_UP:    y_n[i] = y_r[i] - STEP;
                  DIR_DOWN:  y_n[i] = y_r[i] + STEP;
                  DIR_LEFT:  x_n[i] = x_r[i] - STEP;
                  DIR_RIGHT: x_n[i] = x_r[i] + STEP;
                  default:   x_n[i] = x_r[i];
               endcase
            end
         end else if (accept_s && (free_idx_s == i)) begin
            act_n[i] = 1'b1;
            x_n[i]   = player_x;
            y_n[i]   = player_y;
            dir_n[i] = fire_dir;
            age_n[i] = 8'd0;
`ifdef PROJ_BOUNCE_EN
            bnc_n[i] = 1'b0;
`endif
         end else begin
            act_n[i] = act_r[i];
         end
      end
   end

   // State registers; everything but the hit pulse advances only on frame_tick.
   always_ff @(posedge clk or posedge rst_s) begin
      if (rst_s) begin
         for (int i = 0; i < N_SLOTS; i++) begin
            x_r[i]   <= '0;
            y_r[i]   <= '0;
            dir_r[i] <= 2'b00;
            age_r[i] <= 8'd0;
         end
         act_r       <= '0;
`ifdef PROJ_BOUNCE_EN
         bnc_r       <= '0;
`endif
         cool_r      <= 8'd0;
         shots_r     <= 8'd0;
         fire_prev_r <= 1'b0;
         hit_r       <= 1'b0;
      end else begin
         hit_r <= frame_tick & any_hit_s;
         if (frame_tick) begin
            for (int i = 0; i < N_SLOTS; i++) begin
               x_r[i]   <= x_n[i];
               y_r[i]   <= y_n[i];
               dir_r[i] <= dir_n[i];
               age_r[i] <= age_n[i];
            end
            act_r       <= act_n;
`ifdef PROJ_BOUNCE_EN
            bnc_r       <= bnc_n;
`endif
            cool_r      <= cool_n;
            shots_r     <= shots_n;
            fire_prev_r <= fire;
         end else begin
            act_r <= act_r;
         end
      end
   end

   // Pack slot coordinates onto the flat output buses.
   always_comb begin
      bullet_x = '0;
      bullet_y = '0;
      for (int i = 0; i < N_SLOTS; i++) begin
         bullet_x[i*COORD_W +: COORD_W] = x_r[i];
         bullet_y[i*COORD_W +: COORD_W] = y_r[i];
      end
   end

   assign active    = act_r;
   assign hit_pulse = hit_r;
   assign shots     = shots_r;

endmodule

// File: tb/tb_projectile_pool.sv
// Self-checking bench for projectile_pool: directed scenarios plus randomized ticks
// compared against a behavioural model of the slot rules.
module tb_projectile_pool;
   localparam int N  = 3;
   localparam int CW = 10;

   logic            clk = 1'b0;
   logic            reset_ah = 1'b1;
   logic            frame_tick = 1'b0;
   logic            fire = 1'b0;
   logic [1:0]      fire_dir = 2'b11;
   logic            multi_en = 1'b1;
   logic            block_fire = 1'b0;
   logic [CW-1:0]   player_x = 10'd100;
   logic [CW-1:0]   player_y = 10'd200;
   logic [N-1:0]    wall_hit = '0;
   logic [CW-1:0]   target_x = '0;
   logic [CW-1:0]   target_y = '0;
   logic [CW-1:0]   target_s = '0;
   logic [N*CW-1:0] bullet_x;
   logic [N*CW-1:0] bullet_y;
   logic [N-1:0]    active;
   logic            hit_pulse;
   logic [7:0]      shots;

   int n_checks = 0;
   int n_fail   = 0;

   int m_act [N];
   int m_x   [N];
   int m_y   [N];
   int m_dir [N];
   int m_age [N];
   int m_bnc [N];
   int m_cool, m_prev, m_shots, m_hit;

   always #5 clk = ~clk;

   projectile_pool dut (
      .clk(clk), .reset_ah(reset_ah), .frame_tick(frame_tick), .fire(fire),
      .fire_dir(fire_dir), .multi_en(multi_en), .block_fire(block_fire),
      .player_x(player_x), .player_y(player_y), .wall_hit(wall_hit),
      .target_x(target_x), .target_y(target_y), .target_s(target_s),
      .bullet_x(bullet_x), .bullet_y(bullet_y), .active(active),
      .hit_pulse(hit_pulse), .shots(shots)
   );

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         m_act[i] = 0; m_x[i] = 0; m_y[i] = 0; m_dir[i] = 0; m_age[i] = 0; m_bnc[i] = 0;
      end
      m_cool = 0; m_prev = 0; m_shots = 0; m_hit = 0;
   endtask

   // One frame of the game rules, using the inputs currently applied.
   task automatic model_step();
      int cnt = 0;
      int free = -1;
      int lim, nx, ny, tx, ty, ts;
      bit acc, ovl;
      bit any = 0;
      tx = int'(target_x); ty = int'(target_y); ts = int'(target_s);
      for (int i = 0; i < N; i++) begin
         if (m_act[i] != 0) cnt++;
         else if (free < 0) free = i;
      end
      lim = multi_en ? N : 1;
      acc = fire && (m_prev == 0) && !block_fire && (m_cool == 0) && (cnt < lim);
      for (int i = 0; i < N; i++) begin
         if (m_act[i] != 0) begin
            ovl = (m_x[i] < tx + ts) && (tx < m_x[i] + 4) && (m_y[i] < ty + ts) && (ty < m_y[i] + 4);
            nx = m_x[i] + ((m_dir[i] == 3) ? 4 : (m_dir[i] == 2) ? -4 : 0);
            ny = m_y[i] + ((m_dir[i] == 1) ? 4 : (m_dir[i] == 0) ? -4 : 0);
            if (ovl) begin
               m_act[i] = 0; any = 1;
            end else if (wall_hit[i]) begin
`ifdef PROJ_BOUNCE_EN
               if (m_bnc[i] == 0) begin
                  m_bnc[i] = 1;
                  m_dir[i] = (m_dir[i] == 0) ? 1 : (m_dir[i] == 1) ? 0 : (m_dir[i] == 2) ? 3 : 2;
                  m_age[i]++;
               end else m_act[i] = 0;
`else
               m_act[i] = 0;
`endif
            end else if (m_age[i] == 119) begin
               m_act[i] = 0;
            end else if (nx < 0 || nx > 636 || ny < 0 || ny > 476) begin
               m_act[i] = 0;
            end else begin
               m_x[i] = nx; m_y[i] = ny; m_age[i]++;
            end
         end
      end
      if (acc) begin
         m_act[free] = 1; m_x[free] = int'(player_x); m_y[free] = int'(player_y);
         m_dir[free] = int'(fire_dir); m_age[free] = 0; m_bnc[free] = 0;
         m_cool = 8;
         if (m_shots < 255) m_shots++;
      end else if (m_cool > 0) m_cool--;
      m_prev = fire;
      m_hit  = any;
   endtask

   task automatic tick();
      model_step();
      frame_tick = 1'b1;
      @(posedge clk); #1;
      frame_tick = 1'b0;
   endtask

   task automatic idle(input int n);
      frame_tick = 1'b0;
      repeat (n) @(posedge clk);
      #1;
      m_hit = 0;
   endtask

   task automatic do_reset();
      wall_hit = '0; fire = 1'b0; target_s = '0; block_fire = 1'b0; multi_en = 1'b1;
      player_x = 10'd100; player_y = 10'd200; fire_dir = 2'b11;
      reset_ah = 1'b1;
      model_reset();
      @(posedge clk); #1;
      reset_ah = 1'b0;
      idle(3);
   endtask

   task automatic test_reset();
      do_reset();
      n_checks++; if (active !== 3'b000) begin n_fail++; $display("FAIL reset_active: got %b want 000", active); end
      n_checks++; if (bullet_x !== '0 || bullet_y !== '0) begin n_fail++; $display("FAIL reset_xy: got %h/%h want 0", bullet_x, bullet_y); end
      n_checks++; if (hit_pulse !== 1'b0 || shots !== 8'd0) begin n_fail++; $display("FAIL reset_hit_shots: got %b/%0d want 0/0", hit_pulse, shots); end
   endtask

   task automatic test_basic_fire();
      do_reset();
      fire = 1'b1; fire_dir = 2'b11;
      tick();
      n_checks++; if (active !== 3'b001) begin n_fail++; $display("FAIL basic_active: got %b want 001", active); end
      n_checks++; if (bullet_x[CW-1:0] !== 10'd100) begin n_fail++; $display("FAIL basic_spawn_x: got %0d want 100", bullet_x[CW-1:0]); end
      tick();
      n_checks++; if (bullet_x[CW-1:0] !== 10'd104) begin n_fail++; $display("FAIL basic_move_x: got %0d want 104", bullet_x[CW-1:0]); end
      n_checks++; if (shots !== 8'd1) begin n_fail++; $display("FAIL basic_shots: got %0d want 1", shots); end
   endtask

   task automatic test_limit_cooldown();
      do_reset();
      multi_en = 1'b0;
      for (int k = 0; k < 3; k++) begin
         fire = 1'b1; tick();
         n_checks++; if (active !== 3'b001) begin n_fail++; $display("FAIL single_limit_%0d: got %b want 001", k, active); end
         fire = 1'b0; repeat (9) tick();
      end
      n_checks++; if (shots !== 8'd1) begin n_fail++; $display("FAIL single_shots: got %0d want 1", shots); end
      do_reset();
      for (int t = 0; t < 10; t++) begin
         fire = (t == 0 || t == 4 || t == 9);
         tick();
         if (t == 0 || t == 4) begin
            n_checks++; if (active !== 3'b001) begin n_fail++; $display("FAIL cooldown_t%0d: got %b want 001", t, active); end
         end else if (t == 9) begin
            n_checks++; if (active !== 3'b011) begin n_fail++; $display("FAIL cooldown_t9: got %b want 011", active); end
         end
      end
      fire = 1'b0;
   endtask

   task automatic test_lifetime_edge();
      do_reset();
      player_x = 10'd634; fire = 1'b1; tick();
      n_checks++; if (active !== 3'b001) begin n_fail++; $display("FAIL edge_spawn: got %b want 001", active); end
      fire = 1'b0; tick();
      n_checks++; if (active !== 3'b000) begin n_fail++; $display("FAIL edge_retire: got %b want 000", active); end
      repeat (8) tick();
      player_x = 10'd10; fire = 1'b1; tick();
      fire = 1'b0;
      repeat (119) tick();
      n_checks++; if (active[0] !== 1'b1 || bullet_x[CW-1:0] !== 10'd486) begin n_fail++; $display("FAIL life_119: got %b x=%0d want 1 x=486", active[0], bullet_x[CW-1:0]); end
      tick();
      n_checks++; if (active[0] !== 1'b0) begin n_fail++; $display("FAIL life_120: got %b want 0", active[0]); end
   endtask

   task automatic test_hit_priority();
      do_reset();
      fire = 1'b1; tick(); fire = 1'b0;
      target_x = 10'd100; target_y = 10'd200; target_s = 10'd8; wall_hit = 3'b001;
      tick();
      n_checks++; if (hit_pulse !== 1'b1 || active !== 3'b000) begin n_fail++; $display("FAIL hit_wall: got %b/%b want 1/000", hit_pulse, active); end
      wall_hit = '0; target_s = '0;
      idle(1);
      n_checks++; if (hit_pulse !== 1'b0) begin n_fail++; $display("FAIL hit_width: got %b want 0", hit_pulse); end
      do_reset();
      fire = 1'b1; tick(); fire = 1'b0; repeat (8) tick();
      fire = 1'b1; fire_dir = 2'b00; tick(); fire = 1'b0;
      n_checks++; if (active !== 3'b011) begin n_fail++; $display("FAIL hit2_setup: got %b want 011", active); end
      target_x = 10'd0; target_y = 10'd0; target_s = 10'd1023;
      tick();
      n_checks++; if (hit_pulse !== 1'b1 || active !== 3'b000) begin n_fail++; $display("FAIL hit_double: got %b/%b want 1/000", hit_pulse, active); end
      target_s = '0;
      idle(1);
      n_checks++; if (hit_pulse !== 1'b0) begin n_fail++; $display("FAIL hit_double_width: got %b want 0", hit_pulse); end
   endtask

   task automatic test_wall();
      do_reset();
      fire = 1'b1; tick(); fire = 1'b0;
      wall_hit = 3'b001; tick();
`ifdef PROJ_BOUNCE_EN
      n_checks++; if (active !== 3'b001 || bullet_x[CW-1:0] !== 10'd100) begin n_fail++; $display("FAIL bounce_first: got %b x=%0d want 001 x=100", active, bullet_x[CW-1:0]); end
      wall_hit = '0; tick();
      n_checks++; if (bullet_x[CW-1:0] !== 10'd96) begin n_fail++; $display("FAIL bounce_dir: got x=%0d want 96", bullet_x[CW-1:0]); end
      wall_hit = 3'b001; tick();
`endif
      n_checks++; if (active !== 3'b000) begin n_fail++; $display("FAIL wall_retire: got %b want 000", active); end
      wall_hit = '0;
   endtask

   task automatic test_async_reset();
      do_reset();
      for (int k = 0; k < 3; k++) begin
         fire = 1'b1; tick(); fire = 1'b0;
         if (k < 2) repeat (8) tick();
      end
      n_checks++; if (active !== 3'b111) begin n_fail++; $display("FAIL areset_setup: got %b want 111", active); end
      #2 reset_ah = 1'b1;
      #1;
      n_checks++; if (active !== 3'b000 || bullet_x !== '0 || bullet_y !== '0 || shots !== 8'd0 || hit_pulse !== 1'b0)
         begin n_fail++; $display("FAIL areset_clear: act=%b x=%h y=%h shots=%0d hit=%b want all 0", active, bullet_x, bullet_y, shots, hit_pulse); end
      model_reset();
      @(posedge clk); #1;
      reset_ah = 1'b0;
      idle(3);
   endtask

   task automatic test_random();
      logic [N-1:0] exp_act;
      int errs = 0;
      do_reset();
      for (int t = 0; t < 600; t++) begin
         fire       = ($urandom_range(0, 2) == 0);
         fire_dir   = 2'($urandom_range(0, 3));
         multi_en   = ($urandom_range(0, 7) != 0);
         block_fire = ($urandom_range(0, 15) == 0);
         player_x   = 10'($urandom_range(0, 639));
         player_y   = 10'($urandom_range(0, 479));
         for (int i = 0; i < N; i++) wall_hit[i] = ($urandom_range(0, 15) == 0);
         if (t % 20 == 0) begin
            target_x = 10'($urandom_range(0, 639));
            target_y = 10'($urandom_range(0, 479));
            target_s = 10'($urandom_range(0, 60));
         end
         tick();
         for (int i = 0; i < N; i++) exp_act[i] = (m_act[i] != 0);
         n_checks++;
         if (active !== exp_act || hit_pulse !== m_hit[0] || shots !== 8'(m_shots)) begin
            n_fail++; errs++;
            if (errs < 10) $display("FAIL rand_state t=%0d: act=%b hit=%b shots=%0d want %b/%b/%0d", t, active, hit_pulse, shots, exp_act, m_hit[0], m_shots);
         end
         for (int i = 0; i < N; i++) begin
            n_checks++;
            if (bullet_x[i*CW +: CW] !== CW'(m_x[i]) || bullet_y[i*CW +: CW] !== CW'(m_y[i])) begin
               n_fail++; errs++;
               if (errs < 10) $display("FAIL rand_xy t=%0d slot%0d: got %0d,%0d want %0d,%0d", t, i, bullet_x[i*CW +: CW], bullet_y[i*CW +: CW], m_x[i], m_y[i]);
            end
         end
         if ($urandom_range(0, 3) == 0) begin
            idle(1);
            n_checks++; if (hit_pulse !== 1'b0) begin n_fail++; $display("FAIL rand_idle_hit t=%0d: got %b want 0", t, hit_pulse); end
         end
      end
      wall_hit = '0; fire = 1'b0;
   endtask

   initial begin
      model_reset();
      test_reset();
      test_basic_fire();
      test_limit_cooldown();
      test_lifetime_edge();
      test_hit_priority();
      test_wall();
      test_async_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
